// File: rtl/cc_stream_ctrl.sv
// cc_stream_ctrl
// Host-side sequencer for the ChaCha20 encrypt core (cc_encrypt).
// It accepts a command with key, nonce and length, gathers 128-bit plaintext
// words into 512-bit blocks, and drives the core's start / enable-plaintext
// handshake. Ciphertext blocks come back on a valid/ready stream, and each
// block carries a byte count and a last flag.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cfg_valid/o_cfg_ready, i_key, i_non, i_len   command channel
//   i_pt_data/i_pt_valid/o_pt_ready                plaintext word stream
//   o_ct_data/o_ct_valid/i_ct_ready/o_ct_last/o_ct_bytes  ciphertext blocks
//   o_cc_start, o_cc_en_pt, o_cc_key, o_cc_non, o_cc_len, o_cc_pt   to core
//   i_cc_ct, i_cc_rqst_pt, i_cc_done                                from core
//   o_done              one-cycle pulse when the message is finished
module cc_stream_ctrl (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cfg_valid,
  output logic         o_cfg_ready,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_non,
  input  logic [31:0]  i_len,
  input  logic [127:0] i_pt_data,
  input  logic         i_pt_valid,
  output logic         o_pt_ready,
  output logic [511:0] o_ct_data,
  output logic         o_ct_valid,
  input  logic         i_ct_ready,
  output logic         o_ct_last,
  output logic [6:0]   o_ct_bytes,
  output logic         o_cc_start,
  output logic         o_cc_en_pt,
  output logic [255:0] o_cc_key,
  output logic [95:0]  o_cc_non,
  output logic [31:0]  o_cc_len,
  output logic [511:0] o_cc_pt,
  input  logic [511:0] i_cc_ct,
  input  logic         i_cc_rqst_pt,
  input  logic         i_cc_done,
  output logic         o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [95:0]    non_q, non_d;
  logic [31:0]    len_q, len_d;
  logic [26:0]    n_blk_q, n_blk_d;
  logic [26:0]    sent_q, sent_d;
  logic [26:0]    capt_q, capt_d;
  logic [2:0]     word_cnt_q, word_cnt_d;
  logic [511:0]   pt_blk_q, pt_blk_d;
  logic [511:0]   ct_data_q, ct_data_d;
  logic           ct_valid_q, ct_valid_d;
  logic           ct_last_q, ct_last_d;
  logic [6:0]     ct_bytes_q, ct_bytes_d;
  logic           core_done_q, core_done_d;
  logic           cfg_ready_q, cfg_ready_d;
  logic           cc_start_q, cc_start_d;
  logic           cc_en_pt_q, cc_en_pt_d;
  logic           done_q, done_d;

  logic [32:0]    len_sum;
  logic [32:0]    rem_load;
  logic [32:0]    rem_capt;
  logic [2:0]     quota;
  logic [6:0]     capt_bytes;
  logic           pt_ready;
  logic           pt_fire;
  logic           ct_pop;
  logic           cfg_fire;
  logic           blk_done;
  logic           capt_last;

  // Block arithmetic. Bytes still to load for the block being assembled,
  // and bytes still owed at capture, both measured from the latched length.
  // A block needs one word per started 16 bytes, capped at four.
  always_comb begin
    len_sum    = {1'b0, i_len} + 33'd63;
    rem_load   = {1'b0, len_q} - {sent_q, 6'd0};
    rem_capt   = {1'b0, len_q} - {capt_q, 6'd0};
    if (rem_load[32:6] != 27'd0) begin
      quota = 3'd4;
    end else begin
      quota = {1'b0, rem_load[5:4]} + {2'b00, |rem_load[3:0]};
    end
    if (rem_capt[32:6] != 27'd0) begin
      capt_bytes = 7'd64;
    end else begin
      capt_bytes = {1'b0, rem_capt[5:0]};
    end
    capt_last = (capt_q + 27'd1) == n_blk_q;
    pt_ready  = (state_q == S_LOAD) && (word_cnt_q < quota);
    pt_fire   = i_pt_valid && pt_ready;
    ct_pop    = ct_valid_q && i_ct_ready;
    cfg_fire  = i_cfg_valid && cfg_ready_q;
    blk_done  = (word_cnt_q == quota) ||
                (pt_fire && ((word_cnt_q + 3'd1) == quota));
  end

  // Next-state logic. The core cannot be stalled once it is running, so a
  // new block is only issued when the single output buffer is empty or is
  // being emptied this cycle; that guarantees a capture never overwrites an
  // unread block.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    non_d       = non_q;
    len_d       = len_q;
    n_blk_d     = n_blk_q;
    sent_d      = sent_q;
    capt_d      = capt_q;
    word_cnt_d  = word_cnt_q;
    pt_blk_d    = pt_blk_q;
    ct_data_d   = ct_data_q;
    ct_valid_d  = ct_valid_q;
    ct_last_d   = ct_last_q;
    ct_bytes_d  = ct_bytes_q;
    core_done_d = core_done_q | i_cc_done;
    cc_start_d  = 1'b0;
    cc_en_pt_d  = 1'b0;
    done_d      = (state_q == S_FIN);

    if (ct_pop) begin
      ct_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          key_d       = i_key;
          non_d       = i_non;
          len_d       = i_len;
          n_blk_d     = len_sum[32:6];
          sent_d      = 27'd0;
          capt_d      = 27'd0;
          word_cnt_d  = 3'd0;
          pt_blk_d    = '0;
          core_done_d = 1'b0;
          state_d     = (i_len == 32'd0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (pt_fire) begin
          pt_blk_d[{word_cnt_q[1:0], 7'd0} +: 128] = i_pt_data;
          word_cnt_d = word_cnt_q + 3'd1;
        end
        if (blk_done && (!ct_valid_q || ct_pop)) begin
          state_d    = S_ISSUE;
          cc_start_d = (sent_q == 27'd0);
          cc_en_pt_d = (sent_q != 27'd0);
        end
      end
      S_ISSUE: begin
        sent_d  = sent_q + 27'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A request carries the ciphertext of the block just processed; a
        // done only carries data when it delivers a short final block.
        if (i_cc_rqst_pt || (i_cc_done && (capt_q < n_blk_q))) begin
          ct_data_d  = i_cc_ct;
          ct_valid_d = 1'b1;
          ct_bytes_d = capt_bytes;
          ct_last_d  = capt_last;
          capt_d     = capt_q + 27'd1;
          if (capt_last) begin
            state_d = S_DRAIN;
          end else begin
            state_d    = S_LOAD;
            word_cnt_d = 3'd0;
            pt_blk_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (!ct_valid_q && core_done_q) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready lags IDLE entry by a cycle and drops on the accepting edge, so
    // a command can never be taken twice.
    cfg_ready_d = (state_q == S_IDLE) && !cfg_fire;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      non_q       <= '0;
      len_q       <= '0;
      n_blk_q     <= '0;
      sent_q      <= '0;
      capt_q      <= '0;
      word_cnt_q  <= '0;
      pt_blk_q    <= '0;
      ct_data_q   <= '0;
      ct_valid_q  <= 1'b0;
      ct_last_q   <= 1'b0;
      ct_bytes_q  <= '0;
      core_done_q <= 1'b0;
      cfg_ready_q <= 1'b1;
      cc_start_q  <= 1'b0;
      cc_en_pt_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      non_q       <= non_d;
      len_q       <= len_d;
      n_blk_q     <= n_blk_d;
      sent_q      <= sent_d;
      capt_q      <= capt_d;
      word_cnt_q  <= word_cnt_d;
      pt_blk_q    <= pt_blk_d;
      ct_data_q   <= ct_data_d;
      ct_valid_q  <= ct_valid_d;
      ct_last_q   <= ct_last_d;
      ct_bytes_q  <= ct_bytes_d;
      core_done_q <= core_done_d;
      cfg_ready_q <= cfg_ready_d;
      cc_start_q  <= cc_start_d;
      cc_en_pt_q  <= cc_en_pt_d;
      done_q      <= done_d;
    end
  end

  assign o_cfg_ready = cfg_ready_q;
  assign o_pt_ready  = pt_ready;
  assign o_ct_data   = ct_data_q;
  assign o_ct_valid  = ct_valid_q;
  assign o_ct_last   = ct_last_q;
  assign o_ct_bytes  = ct_bytes_q;
  assign o_cc_start  = cc_start_q;
  assign o_cc_en_pt  = cc_en_pt_q;
  assign o_cc_key    = key_q;
  assign o_cc_non    = non_q;
  assign o_cc_len    = len_q;
  assign o_cc_pt     = pt_blk_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_cc_stream_ctrl.sv
// Testbench for cc_stream_ctrl: behavioural core model, plaintext feeder,
// ciphertext sink with optional stall, and directed message scenarios.
module tb_cc_stream_ctrl;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_cfg_valid = 1'b0;
  logic         o_cfg_ready;
  logic [255:0] i_key = '0;
  logic [95:0]  i_non = '0;
  logic [31:0]  i_len = '0;
  logic [127:0] i_pt_data = '0;
  logic         i_pt_valid = 1'b0;
  logic         o_pt_ready;
  logic [511:0] o_ct_data;
  logic         o_ct_valid;
  logic         i_ct_ready;
  logic         o_ct_last;
  logic [6:0]   o_ct_bytes;
  logic         o_cc_start;
  logic         o_cc_en_pt;
  logic [255:0] o_cc_key;
  logic [95:0]  o_cc_non;
  logic [31:0]  o_cc_len;
  logic [511:0] o_cc_pt;
  logic [511:0] i_cc_ct;
  logic         i_cc_rqst_pt;
  logic         i_cc_done;
  logic         o_done;

  cc_stream_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_key(i_key), .i_non(i_non), .i_len(i_len),
    .i_pt_data(i_pt_data), .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready),
    .o_ct_data(o_ct_data), .o_ct_valid(o_ct_valid), .i_ct_ready(i_ct_ready),
    .o_ct_last(o_ct_last), .o_ct_bytes(o_ct_bytes),
    .o_cc_start(o_cc_start), .o_cc_en_pt(o_cc_en_pt),
    .o_cc_key(o_cc_key), .o_cc_non(o_cc_non), .o_cc_len(o_cc_len),
    .o_cc_pt(o_cc_pt), .i_cc_ct(i_cc_ct), .i_cc_rqst_pt(i_cc_rqst_pt),
    .i_cc_done(i_cc_done), .o_done(o_done)
  );

  // Free-running clock and cycle counter used for latency checks
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int assertCount = 0;
  int failCount = 0;

  // Expected message picture, filled in before each command
  int           expN;
  int           curLen;
  logic [511:0] expBlk [0:3];

  // Counters kept by the monitor
  int startCnt, enCnt, beatCnt, doneCnt;
  int popCycle, enCycle, stallLeft;
  logic         holdPending;
  logic [511:0] holdData;
  int           monBlk;

  task automatic checkOutput(input string tag, input logic [511:0] got,
                             input logic [511:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ptWord(input int w);
    logic [31:0] base;
    base = 32'h1000_0000 + 32'(4 * w);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  function automatic logic [511:0] ks(input int b);
    return {16{32'h9E37_0000 | 32'(b)}};
  endfunction

  function automatic int expBytes(input int b);
    int r;
    r = curLen - 64 * b;
    return (r > 64) ? 64 : r;
  endfunction

  // Reference block assembly: word k holds plaintext word 4b+k while the
  // block still has bytes for it, otherwise zero.
  task automatic buildExpected(input int len);
    int r, q;
    curLen = len;
    expN = (len + 63) / 64;
    for (int b = 0; b < 4; b++) begin
      expBlk[b] = '0;
      r = len - 64 * b;
      q = (r <= 0) ? 0 : ((r >= 64) ? 4 : (r + 15) / 16);
      for (int k = 0; k < 4; k++) begin
        if (k < q) expBlk[b][128*k +: 128] = ptWord(4 * b + k);
      end
    end
  endtask

  // Behavioural core: three cycles after start/en_pt it returns the block
  // XOR a per-block keystream, by request or by done for a short tail.
  int           coreBlk = 0, corePend = 0, coreDonePend = 0, coreN;
  logic [511:0] corePt;
  initial begin
    i_cc_rqst_pt = 1'b0;
    i_cc_done    = 1'b0;
    i_cc_ct      = '0;
    corePt       = '0;
    forever begin
      @(negedge i_clk);
      i_cc_rqst_pt = 1'b0;
      i_cc_done    = 1'b0;
      if (i_rst) begin
        corePend = 0;
        coreDonePend = 0;
      end else begin
        coreN = (int'(o_cc_len) + 63) / 64;
        if (coreDonePend > 0) begin
          coreDonePend--;
          if (coreDonePend == 0) i_cc_done = 1'b1;
        end
        if (corePend > 0) begin
          corePend--;
          if (corePend == 0) begin
            i_cc_ct = corePt ^ ks(coreBlk);
            if (coreBlk == coreN - 1) begin
              if (o_cc_len[5:0] == 6'd0) begin
                i_cc_rqst_pt = 1'b1;
                coreDonePend = 3;
              end else begin
                i_cc_done = 1'b1;
              end
            end else begin
              i_cc_rqst_pt = 1'b1;
            end
          end
        end
        if (o_cc_start || o_cc_en_pt) begin
          coreBlk  = o_cc_start ? 0 : coreBlk + 1;
          corePt   = o_cc_pt;
          corePend = 3;
        end
      end
    end
  end

  // Ciphertext sink and handshake monitor
  initial begin
    i_ct_ready  = 1'b1;
    holdPending = 1'b0;
    holdData    = '0;
    forever begin
      @(negedge i_clk);
      if (o_ct_valid && stallLeft > 0) begin
        i_ct_ready = 1'b0;
        stallLeft--;
      end else begin
        i_ct_ready = 1'b1;
      end
      if (i_rst) begin
        holdPending = 1'b0;
      end else begin
        if (o_cc_start || o_cc_en_pt) begin
          monBlk = startCnt + enCnt;
          if (monBlk < 4) checkOutput("ccPt", o_cc_pt, expBlk[monBlk]);
          if (o_cc_start) begin
            startCnt++;
          end else begin
            if (enCnt == 0) enCycle = cyc;
            enCnt++;
          end
        end
        if (o_ct_valid) begin
          if (holdPending) checkOutput("ctHold", o_ct_data, holdData);
          holdPending = !i_ct_ready;
          holdData    = o_ct_data;
        end else begin
          holdPending = 1'b0;
        end
        if (o_ct_valid && i_ct_ready) begin
          if (beatCnt == 0) popCycle = cyc;
          if (beatCnt < 4) begin
            checkOutput("ctData", o_ct_data, expBlk[beatCnt] ^ ks(beatCnt));
            checkOutput("ctBytes", 512'(o_ct_bytes), 512'(expBytes(beatCnt)));
            checkOutput("ctLast", 512'(o_ct_last), 512'(beatCnt == expN - 1));
          end
          beatCnt++;
        end
        if (o_done) doneCnt++;
      end
    end
  end

  task automatic clearCounters();
    startCnt = 0; enCnt = 0; beatCnt = 0; doneCnt = 0;
    popCycle = -1; enCycle = -1; stallLeft = 0;
  endtask

  // Presents a command and returns the cycle in which it was accepted
  task automatic sendCommand(input int len, output int acc);
    acc = -1;
    @(negedge i_clk);
    i_cfg_valid = 1'b1;
    i_key = {8{32'hC0DE_0000 + 32'(len)}};
    i_non = {3{32'h0B0E_0000 + 32'(len)}};
    i_len = 32'(len);
    for (int i = 0; i < 50 && acc < 0; i++) begin
      if (o_cfg_ready) acc = cyc;
      else @(negedge i_clk);
    end
    @(negedge i_clk);
    i_cfg_valid = 1'b0;
    checkOutput("cfgAccepted", 512'(acc >= 0), 512'(1));
    checkOutput("cfgReadyLow", 512'(o_cfg_ready), 512'(0));
    checkOutput("ptReadyT1", 512'(o_pt_ready), 512'(len > 0));
    checkOutput("ccLen", 512'(o_cc_len), 512'(len));
    checkOutput("ccKey", 512'(o_cc_key), 512'({8{32'hC0DE_0000 + 32'(len)}}));
  endtask

  // Feeds ceil(len/16) words, optionally with valid toggling every cycle
  task automatic feedWords(input int nWords, input bit gaps, input int limit);
    int  wIdx;
    bit  toggle;
    wIdx = 0;
    toggle = 1'b1;
    for (int i = 0; i < 3000 && wIdx < limit; i++) begin
      @(negedge i_clk);
      i_pt_valid = !gaps || toggle;
      toggle = !toggle;
      i_pt_data = ptWord(wIdx);
      if (i_pt_valid && o_pt_ready) wIdx++;
    end
    @(negedge i_clk);
    i_pt_valid = 1'b0;
    checkOutput("feedDone", 512'(wIdx), 512'(limit));
    if (nWords < limit) checkOutput("feedCount", 512'(nWords), 512'(limit));
  endtask

  task automatic applyStimulus(input int len, input bit gaps, input int stall);
    int acc, doneAt, nWords;
    buildExpected(len);
    clearCounters();
    stallLeft = stall;
    nWords = (len + 15) / 16;
    sendCommand(len, acc);
    doneAt = -1;
    fork
      feedWords(nWords, gaps, nWords);
      begin
        for (int i = 0; i < 3000 && doneAt < 0; i++) begin
          if (o_done) doneAt = cyc;
          else @(negedge i_clk);
        end
        checkOutput("doneSeen", 512'(o_done), 512'(1));
        checkOutput("cfgReadyAtDone", 512'(o_cfg_ready), 512'(0));
        @(negedge i_clk);
        checkOutput("cfgReadyAfter", 512'(o_cfg_ready), 512'(1));
      end
    join
    repeat (3) @(negedge i_clk);
    checkOutput("startCount", 512'(startCnt), 512'(len > 0));
    checkOutput("enPtCount", 512'(enCnt), 512'((expN > 1) ? expN - 1 : 0));
    checkOutput("beatCount", 512'(beatCnt), 512'(expN));
    checkOutput("doneCount", 512'(doneCnt), 512'(1));
    if (len == 0) checkOutput("zeroLenDoneLat", 512'(doneAt - acc), 512'(2));
    if (stall > 0) checkOutput("enAfterPop", 512'(enCycle), 512'(popCycle + 1));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "CfgReady"}, 512'(o_cfg_ready), 512'(1));
    checkOutput({tag, "PtReady"}, 512'(o_pt_ready), 512'(0));
    checkOutput({tag, "CtValid"}, 512'(o_ct_valid), 512'(0));
    checkOutput({tag, "Done"}, 512'(o_done), 512'(0));
    checkOutput({tag, "Start"}, 512'({o_cc_start, o_cc_en_pt}), 512'(0));
    checkOutput({tag, "CcPt"}, o_cc_pt, 512'(0));
    checkOutput({tag, "CcLen"}, 512'(o_cc_len), 512'(0));
    checkOutput({tag, "CtBytes"}, 512'(o_ct_bytes), 512'(0));
  endtask

  initial begin
    int acc;
    clearCounters();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    checkResetValues("rst");

    $display("[TB] zero length");
    applyStimulus(0, 1'b0, 0);
    $display("[TB] single full block");
    applyStimulus(64, 1'b0, 0);
    $display("[TB] short final block");
    applyStimulus(100, 1'b0, 0);
    $display("[TB] output backpressure");
    applyStimulus(192, 1'b0, 10);
    $display("[TB] input gaps");
    applyStimulus(100, 1'b1, 0);

    $display("[TB] reset mid-block");
    buildExpected(192);
    clearCounters();
    sendCommand(192, acc);
    feedWords(2, 1'b0, 2);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checkResetValues("midRst");
    repeat (2) @(negedge i_clk);
    checkOutput("midRstNoBeat", 512'(beatCnt), 512'(0));
    checkOutput("midRstNoStart", 512'(startCnt), 512'(0));

    $display("[TB] command after reset");
    applyStimulus(64, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cc_stream_ctrl.md
# cc_stream_ctrl

Host-side sequencer for the ChaCha20 encrypt core. It accepts a key/nonce/length command and a 128-bit plaintext word stream, and assembles 512-bit plaintext blocks. It drives the core's start, request and enable-plaintext handshake, and returns ciphertext blocks on a valid/ready stream with byte counts. It sits between the system bus adapter and `cc_encrypt`, and will also front the Poly1305 tag path.

## Interface
Parameters: none.

Clock and reset:
- `i_clk` — input, 1 — clock.
- `i_rst` — input, 1 — reset. One clock; reset is synchronous and active-high.

Command:
- `i_cfg_valid` — input, 1 — command valid.
- `o_cfg_ready` — output, 1 — high only in IDLE.
- `i_key` — input, 256 — key.
- `i_non` — input, 96 — nonce.
- `i_len` — input, 32 — message length in bytes.

Plaintext stream:
- `i_pt_data` — input, 128 — plaintext word; byte 0 in bits [7:0].
- `i_pt_valid` — input, 1 — plaintext word valid.
- `o_pt_ready` — output, 1 — plaintext word ready.

Ciphertext stream:
- `o_ct_data` — output, 512 — ciphertext block.
- `o_ct_valid` — output, 1 — ciphertext block valid.
- `i_ct_ready` — input, 1 — ciphertext block ready.
- `o_ct_last` — output, 1 — final block of the message.
- `o_ct_bytes` — output, 7 — valid bytes in the block, 1..64.

Core side:
- `o_cc_start` — output, 1 — core start pulse.
- `o_cc_en_pt` — output, 1 — core enable-plaintext pulse.
- `o_cc_key` — output, 256 — key to core.
- `o_cc_non` — output, 96 — nonce to core.
- `o_cc_len` — output, 32 — length to core.
- `o_cc_pt` — output, 512 — plaintext block to core.
- `i_cc_ct` — input, 512 — ciphertext from core.
- `i_cc_rqst_pt` — input, 1 — core plaintext request.
- `i_cc_done` — input, 1 — core done.

Status:
- `o_done` — output, 1 — one-cycle pulse at message end.

## Operation
- **Command latch.** The key, nonce and length are latched on an `i_cfg_valid && o_cfg_ready` handshake.
  - `o_cc_key`, `o_cc_non` and `o_cc_len` are driven from these latches and held stable until the next command.
- **Block counts.**
  - N = (len+63)>>6, computed at 33 bits; block counters are 27 bits.
  - Words per block = min(4, ceil(remaining_bytes/16)).
- **Block assembly.**
  - Word k of a block goes to `o_cc_pt` bits [128k+127:128k].
  - Unfilled words are zero.
  - The trailing bytes of a partial word pass through unchanged; the core masks them.
- **States.**
  - IDLE: `o_cfg_ready`=1. On a command: if len==0 go to FIN, else go to LOAD.
  - LOAD: `o_pt_ready`=1 until the block's word count is reached. Go to ISSUE when the block is complete and the output buffer is empty, or is popped this cycle.
  - ISSUE: one cycle. Pulse `o_cc_start` for block 0, otherwise pulse `o_cc_en_pt`. Increment `sent` and go to WAIT.
  - WAIT: capture `i_cc_ct` into the output buffer when `i_cc_rqst_pt`, or `i_cc_done` with captured<N, is seen. Increment `captured`. If captured==N go to DRAIN, else go to LOAD.
  - DRAIN: go to FIN when the output buffer is empty and the core-done flag is set.
  - FIN: `o_done`=1 for one cycle, then go to IDLE.
- **Core-done flag.** Cleared on command accept; set on any `i_cc_done`.
  - When len%64==0, the last block arrives by `i_cc_rqst_pt` and the following `i_cc_done` is ignored for capture.
  - When len%64!=0, the last block arrives by `i_cc_done`.
- **No plaintext after the final request.** `o_cc_en_pt` is never pulsed once sent==N, so a request on the final block gets no plaintext.
- **Backpressure.** The core never stalls its output. Flow control comes only from withholding `o_cc_start` / `o_cc_en_pt` until the single-entry output buffer is free, so a capture can never overwrite an unread block.
- **Output metadata.**
  - `o_ct_bytes` = min(64, bytes remaining at capture).
  - `o_ct_last` = (captured==N) at capture.

## Timing
- Reset values: all outputs are 0 except `o_cfg_ready`=1. The state is IDLE and all counters and the core-done flag are cleared.
- Reset mid-message returns to IDLE on the next edge. No `o_done`, no `o_ct_valid`; partial blocks are discarded.
- Command accepted at cycle t: LOAD at t+1, and `o_pt_ready` is high at t+1.
- Last word of a block accepted at cycle t, buffer free: `o_cc_start` / `o_cc_en_pt` high at t+1.
- Capture at cycle t: `o_ct_valid` is high from t+1 and held, with data stable, until `i_ct_ready`.
- Buffer pop and block completion in the same cycle: ISSUE proceeds on the next cycle, with no bubble.
- `o_pt_ready` is low outside LOAD and after the block's word quota is met.
- `o_done` fires one cycle after DRAIN exits. For len==0 it fires at t+2 with no core activity.

## Test plan
- **Zero length.** len=0 → no `o_cc_start`, no `o_ct_valid`, `o_done` at t+2, `o_cfg_ready` high again at t+3.
- **Single full block.** len=64, 4 words → one `o_cc_start`. The block is captured on `i_cc_rqst_pt` with `o_ct_bytes`=64 and `o_ct_last`=1. The following `i_cc_done` causes no second capture. One `o_done`.
- **Short final block.** len=100 → block 0 takes 4 words, block 1 takes 3 words with word 3 zero.
  - One `o_cc_start` and one `o_cc_en_pt`.
  - Outputs: `o_ct_bytes`=64, then `o_ct_bytes`=36 with `o_ct_last`=1.
- **Output backpressure.** len=192 with `i_ct_ready` low for 10 cycles after the first capture → `o_cc_en_pt` is withheld until the pop, then issued the next cycle. Three blocks are delivered in order.
- **Input gaps and reset.** `i_pt_valid` toggles every cycle → same blocks as with a gapless stream. Asserting `i_rst` mid-block → all outputs reach reset values, and a new command is then processed normally.
